// File: rtl/sa_pe_dbuf.sv
// Systolic-array PE with a double-buffered weight and a two-stage multiply/accumulate pipeline.
// Split mode runs two independent half-width lanes; sums optionally saturate.
module sa_pe_dbuf #(
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = 2*BIT_WIDTH+4,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_weight,
  input  logic                 weight_swap,
  input  logic                 in_valid,
  input  logic                 signed_mode,
  input  logic                 split_mode,
  input  logic                 clear_ovf,
  input  logic [ACC_WIDTH-1:0] input_top,
  input  logic [BIT_WIDTH-1:0] input_left,
  output logic [ACC_WIDTH-1:0] out_bot,
  output logic                 out_bot_valid,
  output logic [BIT_WIDTH-1:0] out_right,
  output logic                 out_right_valid,
  output logic                 ovf
);
  localparam int PW = 2*BIT_WIDTH;
  localparam int HB = BIT_WIDTH/2;
  localparam int HW = ACC_WIDTH/2;

  logic [BIT_WIDTH-1:0] w_act_q, w_act_d, w_shd_q, w_shd_d;
  logic [ACC_WIDTH-1:0] prod_q, prod_d;
  logic                 s1_valid_q, s1_valid_d, s1_signed_q, s1_split_q;
  logic [ACC_WIDTH-1:0] out_bot_q, sum_d;
  logic                 out_bot_valid_q;
  logic [BIT_WIDTH-1:0] out_right_q;
  logic                 out_right_valid_q;
  logic                 ovf_q, ovf_d, ovf_hit;

  logic signed [PW-1:0]        pf_s;
  logic        [PW-1:0]        pf_u;
  logic signed [BIT_WIDTH-1:0] pl_s, ph_s;
  logic        [BIT_WIDTH-1:0] pl_u, ph_u;
  logic        [ACC_WIDTH:0]   full_res;
  logic        [HW:0]          lo_res, hi_res;

  // Returns {overflow, result}; result is clamped only when SATURATE is set.
  function automatic logic [ACC_WIDTH:0] add_full(input logic [ACC_WIDTH-1:0] a,
                                                  input logic [ACC_WIDTH-1:0] b,
                                                  input logic sgn);
    logic [ACC_WIDTH:0]   s;
    logic                 ov;
    logic [ACC_WIDTH-1:0] r;
    s = {1'b0, a} + {1'b0, b};
    if (sgn) begin
      ov = (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
      r  = a[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      ov = s[ACC_WIDTH];
      r  = '1;
    end
    if (!(ov && (SATURATE != 0))) r = s[ACC_WIDTH-1:0];
    return {ov, r};
  endfunction

  function automatic logic [HW:0] add_lane(input logic [HW-1:0] a,
                                           input logic [HW-1:0] b,
                                           input logic sgn);
    logic [HW:0]   s;
    logic          ov;
    logic [HW-1:0] r;
    s = {1'b0, a} + {1'b0, b};
    if (sgn) begin
      ov = (a[HW-1] == b[HW-1]) && (s[HW-1] != a[HW-1]);
      r  = a[HW-1] ? {1'b1, {(HW-1){1'b0}}} : {1'b0, {(HW-1){1'b1}}};
    end else begin
      ov = s[HW];
      r  = '1;
    end
    if (!(ov && (SATURATE != 0))) r = s[HW-1:0];
    return {ov, r};
  endfunction

  // Stage 1: product against the active weight, extended to the accumulator (or lane) width.
  always_comb begin
    pf_s = PW'($signed(input_left)) * PW'($signed(w_act_q));
    pf_u = {{BIT_WIDTH{1'b0}}, input_left} * {{BIT_WIDTH{1'b0}}, w_act_q};
    pl_s = BIT_WIDTH'($signed(input_left[HB-1:0])) * BIT_WIDTH'($signed(w_act_q[HB-1:0]));
    ph_s = BIT_WIDTH'($signed(input_left[BIT_WIDTH-1:HB])) *
           BIT_WIDTH'($signed(w_act_q[BIT_WIDTH-1:HB]));
    pl_u = {{HB{1'b0}}, input_left[HB-1:0]} * {{HB{1'b0}}, w_act_q[HB-1:0]};
    ph_u = {{HB{1'b0}}, input_left[BIT_WIDTH-1:HB]} * {{HB{1'b0}}, w_act_q[BIT_WIDTH-1:HB]};
    prod_d = prod_q;
    s1_valid_d = in_valid & ~load_weight;
    if (s1_valid_d) begin
      if (split_mode) begin
        if (signed_mode) prod_d = {HW'(ph_s), HW'(pl_s)};
        else             prod_d = {HW'(ph_u), HW'(pl_u)};
      end else begin
        if (signed_mode) prod_d = ACC_WIDTH'(pf_s);
        else             prod_d = ACC_WIDTH'(pf_u);
      end
    end
    w_act_d = weight_swap ? w_shd_q : w_act_q;
    w_shd_d = load_weight ? input_left : w_shd_q;
  end

  // Stage 2: accumulate with the partial sum arriving from above this cycle.
  always_comb begin
    full_res = add_full(input_top, prod_q, s1_signed_q);
    lo_res   = add_lane(input_top[HW-1:0], prod_q[HW-1:0], s1_signed_q);
    hi_res   = add_lane(input_top[ACC_WIDTH-1:HW], prod_q[ACC_WIDTH-1:HW], s1_signed_q);
    if (s1_split_q) begin
      sum_d   = {hi_res[HW-1:0], lo_res[HW-1:0]};
      ovf_hit = s1_valid_q & (lo_res[HW] | hi_res[HW]);
    end else begin
      sum_d   = full_res[ACC_WIDTH-1:0];
      ovf_hit = s1_valid_q & full_res[ACC_WIDTH];
    end
    ovf_d = (ovf_q & ~clear_ovf) | ovf_hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_act_q           <= '0;
      w_shd_q           <= '0;
      prod_q            <= '0;
      s1_valid_q        <= 1'b0;
      s1_signed_q       <= 1'b0;
      s1_split_q        <= 1'b0;
      out_bot_q         <= '0;
      out_bot_valid_q   <= 1'b0;
      out_right_q       <= '0;
      out_right_valid_q <= 1'b0;
      ovf_q             <= 1'b0;
    end else begin
      w_act_q           <= w_act_d;
      w_shd_q           <= w_shd_d;
      prod_q            <= prod_d;
      s1_valid_q        <= s1_valid_d;
      if (s1_valid_d) begin
        s1_signed_q <= signed_mode;
        s1_split_q  <= split_mode;
      end
      if (s1_valid_q) out_bot_q <= sum_d;
      out_bot_valid_q   <= s1_valid_q;
      out_right_q       <= input_left;
      out_right_valid_q <= s1_valid_d;
      ovf_q             <= ovf_d;
    end
  end

  assign out_bot         = out_bot_q;
  assign out_bot_valid   = out_bot_valid_q;
  assign out_right       = out_right_q;
  assign out_right_valid = out_right_valid_q;
  assign ovf             = ovf_q;
endmodule

// File: tb/tb_sa_pe_dbuf.sv
// Bench for sa_pe_dbuf: directed scenarios plus a randomized run against an
// integer-arithmetic model of the PE.
module tb_sa_pe_dbuf;
  localparam int BW  = 8;
  localparam int AW  = 20;
  localparam int HWL = AW/2;
  localparam int HB  = BW/2;
  localparam bit SAT = 1'b1;

  logic          clk, reset;
  logic          load_weight, weight_swap, in_valid, signed_mode, split_mode, clear_ovf;
  logic [AW-1:0] input_top;
  logic [BW-1:0] input_left;
  logic [AW-1:0] out_bot;
  logic          out_bot_valid;
  logic [BW-1:0] out_right;
  logic          out_right_valid;
  logic          ovf;

  int checks = 0;
  int failures = 0;
  logic [AW-1:0] exp_q[$];

  // Model state
  logic [BW-1:0] m_wa, m_ws, m_x, m_w, m_or;
  bit            m_s1_v, m_sg, m_sp, m_obv, m_orv, m_ovf;
  logic [AW-1:0] m_ob;

  sa_pe_dbuf #(.BIT_WIDTH(BW), .ACC_WIDTH(AW), .SATURATE(1)) dut (
    .clk(clk), .reset(reset), .load_weight(load_weight), .weight_swap(weight_swap),
    .in_valid(in_valid), .signed_mode(signed_mode), .split_mode(split_mode),
    .clear_ovf(clear_ovf), .input_top(input_top), .input_left(input_left),
    .out_bot(out_bot), .out_bot_valid(out_bot_valid), .out_right(out_right),
    .out_right_valid(out_right_valid), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint sx(longint v, int w);
    return (v >= (longint'(1) << (w-1))) ? v - (longint'(1) << w) : v;
  endfunction

  // Bring an exact sum into a w-bit signed/unsigned range: clamp or wrap.
  function automatic longint fit(longint v, int w, bit sg, output bit ov);
    longint lo, hi;
    lo = sg ? -(longint'(1) << (w-1)) : 0;
    hi = sg ? (longint'(1) << (w-1)) - 1 : (longint'(1) << w) - 1;
    ov = (v < lo) || (v > hi);
    if (ov && SAT) v = (v < lo) ? lo : hi;
    return v & ((longint'(1) << w) - 1);
  endfunction

  task automatic model_zero();
    m_wa = '0; m_ws = '0; m_x = '0; m_w = '0; m_or = '0; m_ob = '0;
    m_s1_v = 0; m_sg = 0; m_sp = 0; m_obv = 0; m_orv = 0; m_ovf = 0;
  endtask

  task automatic idle();
    load_weight = 0; weight_swap = 0; in_valid = 0; signed_mode = 0;
    split_mode = 0; clear_ovf = 0; input_top = '0; input_left = '0;
  endtask

  // One clock edge; the model advances using the inputs present at the edge.
  task automatic step();
    bit ov, ovk;
    longint a, xa, wa, r, res;
    @(posedge clk);
    if (!reset) begin
      model_zero();
    end else begin
      ov = 0;
      if (m_s1_v) begin
        res = 0;
        if (!m_sp) begin
          a = longint'(input_top); xa = longint'(m_x); wa = longint'(m_w);
          if (m_sg) begin a = sx(a, AW); xa = sx(xa, BW); wa = sx(wa, BW); end
          res = fit(a + xa * wa, AW, m_sg, ov);
        end else begin
          for (int k = 0; k < 2; k++) begin
            a  = (longint'(input_top) >> (k*HWL)) & ((longint'(1) << HWL) - 1);
            xa = (longint'(m_x) >> (k*HB)) & ((longint'(1) << HB) - 1);
            wa = (longint'(m_w) >> (k*HB)) & ((longint'(1) << HB) - 1);
            if (m_sg) begin a = sx(a, HWL); xa = sx(xa, HB); wa = sx(wa, HB); end
            r = fit(a + xa * wa, HWL, m_sg, ovk);
            res = res | (r << (k*HWL));
            ov = ov | ovk;
          end
        end
        m_ob = res[AW-1:0];
      end
      m_ovf = (m_ovf && !clear_ovf) || ov;
      m_obv = m_s1_v;
      m_s1_v = in_valid && !load_weight;
      if (m_s1_v) begin m_x = input_left; m_w = m_wa; m_sg = signed_mode; m_sp = split_mode; end
      m_or = input_left;
      m_orv = m_s1_v;
      if (weight_swap) m_wa = m_ws;
      if (load_weight) m_ws = input_left;
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({out_bot, out_bot_valid, out_right, out_right_valid, ovf} !== '0) begin
      failures++; $display("FAIL reset_initial got=%h exp=0", {out_bot, out_bot_valid, out_right, out_right_valid, ovf});
    end
    model_zero();
    step();
    reset = 1'b1;
    // Put data in flight, then pull reset between edges.
    load_weight = 1; input_left = 8'd4; step();
    idle(); weight_swap = 1; step();
    idle(); in_valid = 1; input_left = 8'd9; step();
    input_top = 20'd50; step();
    #2 reset = 1'b0;
    #1;
    model_zero();
    checks++;
    if ({out_bot, out_bot_valid, out_right, out_right_valid, ovf} !== '0) begin
      failures++; $display("FAIL reset_async got=%h exp=0", {out_bot, out_bot_valid, out_right, out_right_valid, ovf});
    end
    step(); step();
    checks++;
    if ({out_bot, out_bot_valid, out_right, out_right_valid, ovf} !== '0) begin
      failures++; $display("FAIL reset_held got=%h exp=0", {out_bot, out_bot_valid, out_right, out_right_valid, ovf});
    end
    idle(); reset = 1'b1;
    step(); step();
    checks++;
    if ({out_bot, out_bot_valid, out_right, out_right_valid, ovf} !== '0) begin
      failures++; $display("FAIL reset_release got=%h exp=0", {out_bot, out_bot_valid, out_right, out_right_valid, ovf});
    end
    // Active weight is 0 after reset, so the first result is just input_top.
    in_valid = 1; input_left = 8'd7; step();
    checks++;
    if (out_bot_valid !== 1'b0) begin
      failures++; $display("FAIL reset_latency1 got=%b exp=0", out_bot_valid);
    end
    idle(); input_top = 20'd33; step();
    checks++;
    if (out_bot_valid !== 1'b1 || out_bot !== 20'd33) begin
      failures++; $display("FAIL reset_latency2 got=%b/%0d exp=1/33", out_bot_valid, out_bot);
    end
  endtask

  task automatic test_basic();
    idle(); load_weight = 1; input_left = 8'd3; step();
    idle(); weight_swap = 1; step();
    idle(); in_valid = 1; input_left = 8'd5; step();
    checks++;
    if (out_right !== 8'd5 || out_right_valid !== 1'b1) begin
      failures++; $display("FAIL basic_out_right got=%0d/%b exp=5/1", out_right, out_right_valid);
    end
    idle(); input_top = 20'd100; step();
    checks++;
    if (out_bot !== 20'd115 || out_bot_valid !== 1'b1) begin
      failures++; $display("FAIL basic_out_bot got=%0d/%b exp=115/1", out_bot, out_bot_valid);
    end
    idle(); step();
    checks++;
    if (out_bot !== 20'd115 || out_bot_valid !== 1'b0) begin
      failures++; $display("FAIL basic_hold got=%0d/%b exp=115/0", out_bot, out_bot_valid);
    end
  endtask

  task automatic test_signed();
    idle(); load_weight = 1; input_left = 8'hFE; step();
    idle(); weight_swap = 1; step();
    idle(); in_valid = 1; signed_mode = 1; input_left = 8'hFD; step();
    idle(); input_top = 20'hFFFF6; step();
    checks++;
    if (out_bot !== 20'hFFFFC || out_bot_valid !== 1'b1 || ovf !== 1'b0) begin
      failures++; $display("FAIL signed_sum got=%h/%b/%b exp=ffffc/1/0", out_bot, out_bot_valid, ovf);
    end
  endtask

  task automatic test_double_buffer();
    logic [BW-1:0] xs[7];
    bit lds[7], sws[7], ivs[7];
    int got;
    xs  = '{8'd3, 8'd0, 8'd7, 8'd1, 8'd1, 8'd1, 8'd0};
    lds = '{1, 0, 1, 0, 0, 0, 0};
    sws = '{0, 1, 0, 0, 1, 0, 0};
    ivs = '{0, 0, 0, 1, 1, 1, 0};
    exp_q.delete();
    exp_q.push_back(20'd3); exp_q.push_back(20'd3); exp_q.push_back(20'd7);
    got = 0;
    for (int i = 0; i < 9; i++) begin
      idle();
      if (i < 7) begin
        load_weight = lds[i]; weight_swap = sws[i]; in_valid = ivs[i]; input_left = xs[i];
      end
      step();
      if (out_bot_valid === 1'b1) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL dbuf_extra got=%0d exp=none", out_bot);
        end else if (out_bot !== exp_q[0]) begin
          failures++; $display("FAIL dbuf_product got=%0d exp=%0d", out_bot, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
    checks++;
    if (got !== 3) begin
      failures++; $display("FAIL dbuf_count got=%0d exp=3", got);
    end
  endtask

  task automatic test_saturation();
    idle(); load_weight = 1; input_left = 8'd2; step();
    idle(); weight_swap = 1; step();
    idle(); in_valid = 1; signed_mode = 1; input_left = 8'd2; step();
    idle(); input_top = 20'd524286; step();
    checks++;
    if (out_bot !== 20'd524287 || ovf !== 1'b1) begin
      failures++; $display("FAIL sat_pos got=%0d/%b exp=524287/1", out_bot, ovf);
    end
    idle(); step(); step(); step();
    checks++;
    if (ovf !== 1'b1) begin
      failures++; $display("FAIL sat_sticky got=%b exp=1", ovf);
    end
    clear_ovf = 1; step();
    checks++;
    if (ovf !== 1'b0) begin
      failures++; $display("FAIL sat_clear got=%b exp=0", ovf);
    end
    idle(); in_valid = 1; signed_mode = 1; input_left = 8'hFE; step();
    idle(); input_top = 20'h80000; clear_ovf = 1; step();
    checks++;
    if (out_bot !== 20'h80000 || ovf !== 1'b1) begin
      failures++; $display("FAIL sat_neg_with_clear got=%h/%b exp=80000/1", out_bot, ovf);
    end
    idle(); clear_ovf = 1; step();
    idle(); in_valid = 1; input_left = 8'd1; step();
    idle(); input_top = 20'hFFFFF; step();
    checks++;
    if (out_bot !== 20'hFFFFF || ovf !== 1'b1) begin
      failures++; $display("FAIL sat_unsigned got=%h/%b exp=fffff/1", out_bot, ovf);
    end
    idle(); clear_ovf = 1; step();
  endtask

  task automatic test_split();
    idle(); load_weight = 1; input_left = 8'h45; step();
    idle(); weight_swap = 1; step();
    idle(); in_valid = 1; split_mode = 1; input_left = 8'h23; step();
    idle(); input_top = {10'd1, 10'd10}; step();
    checks++;
    if (out_bot !== {10'd9, 10'd25} || ovf !== 1'b0 || out_bot_valid !== 1'b1) begin
      failures++; $display("FAIL split_lanes got=%h/%b exp=%h/0", out_bot, ovf, {10'd9, 10'd25});
    end
  endtask

  task automatic test_load_priority();
    idle(); load_weight = 1; in_valid = 1; input_left = 8'd9; step();
    checks++;
    if (out_right_valid !== 1'b0 || out_right !== 8'd9) begin
      failures++; $display("FAIL load_pri_right got=%0d/%b exp=9/0", out_right, out_right_valid);
    end
    idle(); weight_swap = 1; step();
    checks++;
    if (out_bot_valid !== 1'b0) begin
      failures++; $display("FAIL load_pri_no_compute got=%b exp=0", out_bot_valid);
    end
    idle(); in_valid = 1; input_left = 8'd1; step();
    idle(); step();
    checks++;
    if (out_bot !== 20'd9 || out_bot_valid !== 1'b1) begin
      failures++; $display("FAIL load_pri_weight got=%0d/%b exp=9/1", out_bot, out_bot_valid);
    end
  endtask

  task automatic test_random();
    logic [AW+BW+2:0] got_v, exp_v;
    for (int i = 0; i < 600; i++) begin
      load_weight = ($urandom_range(0, 7) == 0);
      weight_swap = ($urandom_range(0, 7) == 0);
      in_valid    = ($urandom_range(0, 1) == 1);
      signed_mode = ($urandom_range(0, 1) == 1);
      split_mode  = ($urandom_range(0, 2) == 0);
      clear_ovf   = ($urandom_range(0, 15) == 0);
      input_left  = BW'($urandom);
      case ($urandom_range(0, 3))
        0:       input_top = 20'h7FFF0 + AW'($urandom_range(0, 31));
        1:       input_top = {10'h1FF - 10'($urandom_range(0, 7)), 10'h3FF - 10'($urandom_range(0, 7))};
        default: input_top = AW'($urandom);
      endcase
      step();
      got_v = {out_bot, out_bot_valid, out_right, out_right_valid, ovf};
      exp_v = {m_ob, m_obv, m_or, m_orv, m_ovf};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL random_cycle%0d got=%h/%b/%h/%b/%b exp=%h/%b/%h/%b/%b", i,
                 out_bot, out_bot_valid, out_right, out_right_valid, ovf,
                 m_ob, m_obv, m_or, m_orv, m_ovf);
      end
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    model_zero();
    test_reset();
    test_basic();
    test_signed();
    test_double_buffer();
    test_saturation();
    test_split();
    test_load_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
